// File: rtl/frame_cipher_buffer_if.sv
// frame_cipher_buffer_if: four-phase symbol handshake between a frame source and the cipher buffer.
interface frame_cipher_buffer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] In_Data;
  logic In_Valid;
  logic In_Ack;
  modport master (output In_Data, In_Valid, input In_Ack);
  modport slave (input In_Data, In_Valid, output In_Ack);
endinterface

// File: rtl/frame_cipher_buffer.sv
// frame_cipher_buffer: receives a length-prefixed data/key frame, ciphers it one symbol per cycle,
// then lets the result buffer be browsed by index.
module frame_cipher_buffer #(
  parameter int WIDTH = 8,
  parameter int DATA_DEPTH = 100,
  parameter int KEY_DEPTH = 8,
  parameter int IDX_W = 8
) (
  input  logic Clk_100M,
  input  logic Reset,
  frame_cipher_buffer_if.slave bus,
  input  logic [1:0] Mode,
  input  logic Prev_Pulse,
  input  logic Next_Pulse,
  output logic Busy,
  output logic Done,
  output logic Error,
  output logic [IDX_W-1:0] Data_Len,
  output logic [IDX_W-1:0] Cur_Index,
  output logic [WIDTH-1:0] Cur_Plain,
  output logic [WIDTH-1:0] Cur_Cipher
);
  localparam int DA = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;
  localparam int KA = KEY_DEPTH > 1 ? $clog2(KEY_DEPTH) : 1;
  localparam logic [IDX_W-1:0] DMAX = IDX_W'(DATA_DEPTH);
  localparam logic [IDX_W-1:0] KMAX = IDX_W'(KEY_DEPTH);
  typedef enum logic [2:0] {IDLE, RX_DATA, RX_KLEN, RX_KEY, CIPHER, DONE, ERR} state_t;
  state_t state;
  logic [WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [WIDTH-1:0] key_mem [KEY_DEPTH];
  logic [WIDTH-1:0] res_mem [DATA_DEPTH];
  logic [IDX_W-1:0] key_len, cnt, kcnt, len;
  logic [1:0] mode_r;
  logic in_ack, accept, bad_n, bad_k;
  logic [WIDTH-1:0] dsym, ksym, result;
  assign bus.In_Ack = in_ack;
  assign len = bus.In_Data[IDX_W-1:0];
  assign accept = bus.In_Valid && !in_ack && state != CIPHER;
  assign bad_n = len == '0 || len > DMAX;
  assign bad_k = len == '0 || len > KMAX;
  assign dsym = data_mem[cnt[DA-1:0]];
  assign ksym = key_mem[kcnt[KA-1:0]];
  assign result = mode_r == 2'b00 ? dsym ^ ksym :
                  mode_r == 2'b01 ? dsym + ksym :
                  mode_r == 2'b10 ? dsym - ksym : dsym;
  assign Busy = !(state inside {IDLE, DONE, ERR});
  assign Cur_Plain = Done ? data_mem[Cur_Index[DA-1:0]] : '0;
  assign Cur_Cipher = Done ? res_mem[Cur_Index[DA-1:0]] : '0;
  // Buffers carry no reset so they map onto plain RAM.
  always_ff @(posedge Clk_100M) begin
    if (!Reset && accept && state == RX_DATA) data_mem[cnt[DA-1:0]] <= bus.In_Data;
    if (!Reset && accept && state == RX_KEY) key_mem[kcnt[KA-1:0]] <= bus.In_Data;
    if (!Reset && state == CIPHER) res_mem[cnt[DA-1:0]] <= result;
  end
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state <= IDLE;
      in_ack <= 1'b0;
      Done <= 1'b0;
      Error <= 1'b0;
      Data_Len <= '0;
      Cur_Index <= '0;
      key_len <= '0;
      cnt <= '0;
      kcnt <= '0;
      mode_r <= 2'b00;
    end else begin
      in_ack <= accept || (in_ack && bus.In_Valid);
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            Done <= 1'b0;
            if (bad_n) begin
              state <= ERR;
              Error <= 1'b1;
            end else begin
              Data_Len <= len;
              cnt <= '0;
              state <= RX_DATA;
            end
          end else if (state == DONE && (Prev_Pulse ^ Next_Pulse)) begin
            Cur_Index <= Next_Pulse ? (Cur_Index == Data_Len - 1'b1 ? '0 : Cur_Index + 1'b1)
                                    : (Cur_Index == '0 ? Data_Len - 1'b1 : Cur_Index - 1'b1);
          end
        end
        RX_DATA: if (accept) begin
          cnt <= cnt + 1'b1;
          if (cnt == Data_Len - 1'b1) state <= RX_KLEN;
        end
        RX_KLEN: if (accept) begin
          if (bad_k) begin
            state <= ERR;
            Error <= 1'b1;
          end else begin
            key_len <= len;
            kcnt <= '0;
            state <= RX_KEY;
          end
        end
        RX_KEY: if (accept) begin
          if (kcnt == key_len - 1'b1) begin
            mode_r <= Mode;
            cnt <= '0;
            kcnt <= '0;
            state <= CIPHER;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
        CIPHER: begin
          cnt <= cnt + 1'b1;
          kcnt <= kcnt == key_len - 1'b1 ? '0 : kcnt + 1'b1;
          if (cnt == Data_Len - 1'b1) begin
            state <= DONE;
            Done <= 1'b1;
            Cur_Index <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
